// File: rtl/spi_master_fifo.sv
// SPI master (modes 0-3) fed by a TX FIFO; bursts run while the FIFO holds words.
// Define SPI_MISO_CAPTURE_EN to capture MISO onto m_valid/m_data.
module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int NUM_CS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [1:0]                    cs_sel,
    output logic                          spi_sclk,
    output logic                          spi_mosi,
    input  logic                          spi_miso,
    output logic [NUM_CS-1:0]             spi_cs_n,
    output logic                          m_valid,
    output logic [DATA_W-1:0]             m_data,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);
    localparam logic [EW-1:0] EDGE_PEN  = EW'(2 * DATA_W - 2);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] tx_sr, head;
    logic [DW-1:0]     div_cnt;
    logic [EW-1:0]     edge_cnt;
    logic              cpol, cpha;
    logic              full, push, pop, have, tick, lead, last;
    logic [NUM_CS-1:0] cs_mask;

    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign s_ready    = !full;
    assign push       = s_valid && !full;
    assign have       = count != '0;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign tick       = div_cnt == DIV_LAST;
    assign lead       = !edge_cnt[0];
    assign last       = edge_cnt == EDGE_LAST;
    assign pop        = have && ((state == IDLE && start) ||
                                 (state == SHIFT && tick && last));

    // Out-of-range selects fall back to CS0.
    always_comb begin
        cs_mask = '0;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(cs_sel) == i) cs_mask[i] = 1'b1;
        if (int'(cs_sel) >= NUM_CS) cs_mask[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            spi_cs_n <= '1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            tx_sr    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    spi_mosi <= 1'b0;
                    if (start && have) begin
                        cpol     <= mode[1];
                        cpha     <= mode[0];
                        spi_sclk <= mode[1];
                        spi_cs_n <= ~cs_mask;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        tx_sr    <= mode[0] ? head : {head[DATA_W-2:0], 1'b0};
                        if (!mode[0]) spi_mosi <= head[DATA_W-1];
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) begin
                        spi_sclk <= ~spi_sclk;
                        if ((lead && cpha) || (!lead && !cpha && !last)) begin
                            spi_mosi <= tx_sr[DATA_W-1];
                            tx_sr    <= tx_sr << 1;
                        end
                        if (last) begin
                            edge_cnt <= '0;
                            if (have) begin
                                tx_sr <= cpha ? head : {head[DATA_W-2:0], 1'b0};
                                if (!cpha) spi_mosi <= head[DATA_W-1];
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            edge_cnt <= edge_cnt + EW'(1);
                        end
                    end
                end
                HOLD: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) begin
                        spi_cs_n <= '1;
                        spi_mosi <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_MISO_CAPTURE_EN
    logic [DATA_W-1:0] rx_sr, rx_next;
    logic              samp, fin;

    // Sample on the leading edge for CPHA=0, trailing edge for CPHA=1.
    assign rx_next = {rx_sr[DATA_W-2:0], spi_miso};
    assign samp    = state == SHIFT && tick && (lead != cpha);
    assign fin     = samp && (cpha ? last : edge_cnt == EDGE_PEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            m_valid <= fin;
            if (samp) rx_sr  <= rx_next;
            if (fin)  m_data <= rx_next;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign m_valid     = 1'b0;
    assign m_data      = '0;
`endif

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo (DATA_W=8, FIFO_DEPTH=8, CLK_DIV=2, NUM_CS=2).
// MISO is looped back from MOSI.
module tb_spi_master_fifo;

    logic       clk = 0, rst_n = 0;
    logic       s_valid = 0, start = 0;
    logic [7:0] s_data = 0;
    logic [1:0] mode = 0, cs_sel = 0;
    logic       s_ready, spi_sclk, spi_mosi, spi_miso, m_valid, busy, done;
    logic [1:0] spi_cs_n;
    logic [7:0] m_data;
    logic [3:0] fifo_count;
    int total = 0, bad = 0;

    assign spi_miso = spi_mosi;
    always #5 clk = ~clk;

    spi_master_fifo #(
        .DATA_W(8), .FIFO_DEPTH(8), .CLK_DIV(2), .NUM_CS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .start(start), .mode(mode), .cs_sel(cs_sel),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .m_valid(m_valid), .m_data(m_data),
        .busy(busy), .done(done), .fifo_count(fifo_count)
    );

    task automatic push(input logic [7:0] w);
        s_valid = 1; s_data = w;
        @(posedge clk); #1;
        s_valid = 0;
    endtask

    task automatic run_burst(
        input  logic [1:0]  md_i, input logic [1:0] cs_i, input int mid_at,
        output int          pulses, output logic [63:0] bits,
        output int          done_at, output int done_cnt,
        output int          cs_asserts, output logic [1:0] cs_val,
        output int          span, output int mv_cnt, output logic [7:0] mdat);
        logic prev_sclk, prev_idle;
        int first_rise, last_rise, tail;
        pulses = 0; bits = 0; done_at = 0; done_cnt = 0; cs_asserts = 0;
        cs_val = 2'b11; mv_cnt = 0; mdat = 0;
        first_rise = -1; last_rise = -1; tail = -1;
        prev_sclk = md_i[1]; prev_idle = 1;
        mode = md_i; cs_sel = cs_i; start = 1;
        for (int n = 1; n <= 600 && tail != 0; n++) begin
            @(posedge clk); #1;
            start = (n == mid_at);
            if (n == mid_at) begin mode = ~md_i; cs_sel = ~cs_i; end
            if (spi_cs_n != 2'b11 && prev_idle) cs_asserts++;
            if (spi_cs_n != 2'b11) cs_val = spi_cs_n;
            prev_idle = (spi_cs_n == 2'b11);
            if (spi_sclk != prev_sclk) begin
                if (spi_sclk != md_i[1]) begin
                    pulses++;
                    if (first_rise < 0) first_rise = n;
                    last_rise = n;
                    if (!md_i[0]) bits = {bits[62:0], spi_mosi};
                end else if (md_i[0]) begin
                    bits = {bits[62:0], spi_mosi};
                end
            end
            prev_sclk = spi_sclk;
            if (m_valid) begin mv_cnt++; mdat = m_data; end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
                tail = 6;
            end
            if (tail > 0) tail--;
        end
        start = 0;
        span = last_rise - first_rise;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (spi_cs_n !== 2'b11) begin bad++; $display("FAIL rst_cs got=%b exp=11", spi_cs_n); end
        total++; if (spi_sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b exp=0", spi_sclk); end
        total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b exp=0", spi_mosi); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
        total++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin bad++; $display("FAIL rst_rx got=%b/%h exp=0/00", m_valid, m_data); end
        total++; if (fifo_count !== 4'd0 || s_ready !== 1'b1) begin bad++; $display("FAIL rst_fifo got=%0d/%b exp=0/1", fifo_count, s_ready); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int p, da, dc, ca, sp, mv; logic [63:0] b; logic [1:0] cv; logic [7:0] md;
        push(8'hA5);
        run_burst(2'd0, 2'd0, 0, p, b, da, dc, ca, cv, sp, mv, md);
        total++; if (cv !== 2'b10) begin bad++; $display("FAIL single_cs got=%b exp=10", cv); end
        total++; if (p != 8) begin bad++; $display("FAIL single_pulses got=%0d exp=8", p); end
        total++; if (b[7:0] !== 8'hA5) begin bad++; $display("FAIL single_mosi got=%h exp=a5", b[7:0]); end
        total++; if (da != 37) begin bad++; $display("FAIL single_done_at got=%0d exp=37", da); end
        total++; if (dc != 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", dc); end
        total++; if (spi_cs_n !== 2'b11 || busy !== 1'b0) begin bad++; $display("FAIL single_end got=%b/%b exp=11/0", spi_cs_n, busy); end
    endtask

    task automatic test_back_to_back;
        int p, da, dc, ca, sp, mv; logic [63:0] b; logic [1:0] cv; logic [7:0] md;
        push(8'h3C); push(8'h81); push(8'hFF);
        run_burst(2'd0, 2'd1, 0, p, b, da, dc, ca, cv, sp, mv, md);
        total++; if (ca != 1) begin bad++; $display("FAIL b2b_cs_asserts got=%0d exp=1", ca); end
        total++; if (cv !== 2'b01) begin bad++; $display("FAIL b2b_cs got=%b exp=01", cv); end
        total++; if (p != 24) begin bad++; $display("FAIL b2b_pulses got=%0d exp=24", p); end
        total++; if (sp != 92) begin bad++; $display("FAIL b2b_span got=%0d exp=92", sp); end
        total++; if (b[23:0] !== 24'h3C81FF) begin bad++; $display("FAIL b2b_mosi got=%h exp=3c81ff", b[23:0]); end
        total++; if (da != 101 || dc != 1) begin bad++; $display("FAIL b2b_done got=%0d/%0d exp=101/1", da, dc); end
    endtask

    task automatic test_mode3;
        int p, da, dc, ca, sp, mv; logic [63:0] b; logic [1:0] cv; logic [7:0] md;
        push(8'h5A);
        run_burst(2'd3, 2'd1, 0, p, b, da, dc, ca, cv, sp, mv, md);
        total++; if (cv !== 2'b01) begin bad++; $display("FAIL m3_cs got=%b exp=01", cv); end
        total++; if (spi_sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_idle got=%b exp=1", spi_sclk); end
        total++; if (p != 8 || b[7:0] !== 8'h5A) begin bad++; $display("FAIL m3_tx got=%0d/%h exp=8/5a", p, b[7:0]); end
`ifdef SPI_MISO_CAPTURE_EN
        total++; if (mv != 1 || md !== 8'h5A) begin bad++; $display("FAIL m3_rx got=%0d/%h exp=1/5a", mv, md); end
`else
        total++; if (mv != 0 || m_data !== 8'h00) begin bad++; $display("FAIL m3_rx got=%0d/%h exp=0/00", mv, m_data); end
`endif
        total++; if (da != 37 || dc != 1) begin bad++; $display("FAIL m3_done got=%0d/%0d exp=37/1", da, dc); end
    endtask

    task automatic test_cs_range;
        int p, da, dc, ca, sp, mv; logic [63:0] b; logic [1:0] cv; logic [7:0] md;
        push(8'h0F);
        run_burst(2'd1, 2'd3, 0, p, b, da, dc, ca, cv, sp, mv, md);
        total++; if (cv !== 2'b10) begin bad++; $display("FAIL csrange_cs got=%b exp=10", cv); end
        total++; if (b[7:0] !== 8'h0F) begin bad++; $display("FAIL csrange_mosi got=%h exp=0f", b[7:0]); end
    endtask

    task automatic test_full;
        int p, da, dc, ca, sp, mv; logic [63:0] b; logic [1:0] cv; logic [7:0] md;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        total++; if (fifo_count !== 4'd8 || s_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=8/0", fifo_count, s_ready); end
        push(8'h99);
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_drop got=%0d exp=8", fifo_count); end
        run_burst(2'd0, 2'd0, 0, p, b, da, dc, ca, cv, sp, mv, md);
        total++; if (p != 64) begin bad++; $display("FAIL full_pulses got=%0d exp=64", p); end
        total++; if (b !== 64'h1011121314151617) begin bad++; $display("FAIL full_mosi got=%h exp=1011121314151617", b); end
        total++; if (da != 261 || dc != 1) begin bad++; $display("FAIL full_done got=%0d/%0d exp=261/1", da, dc); end
        total++; if (fifo_count !== 4'd0 || s_ready !== 1'b1) begin bad++; $display("FAIL full_empty got=%0d/%b exp=0/1", fifo_count, s_ready); end
    endtask

    task automatic test_empty_start;
        int act;
        act = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 20; i++) begin
            if (spi_cs_n !== 2'b11 || done || busy) act++;
            @(posedge clk); #1;
        end
        total++; if (act != 0) begin bad++; $display("FAIL empty_start got=%0d exp=0", act); end
    endtask

    task automatic test_mid_start;
        int p, da, dc, ca, sp, mv; logic [63:0] b; logic [1:0] cv; logic [7:0] md;
        push(8'hA5);
        run_burst(2'd0, 2'd0, 10, p, b, da, dc, ca, cv, sp, mv, md);
        total++; if (da != 37 || dc != 1) begin bad++; $display("FAIL mid_done got=%0d/%0d exp=37/1", da, dc); end
        total++; if (ca != 1 || cv !== 2'b10) begin bad++; $display("FAIL mid_cs got=%0d/%b exp=1/10", ca, cv); end
        total++; if (p != 8 || b[7:0] !== 8'hA5) begin bad++; $display("FAIL mid_tx got=%0d/%h exp=8/a5", p, b[7:0]); end
        mode = 0; cs_sel = 0;
    endtask

    task automatic test_reset_mid;
        int leads, seen;
        logic prev;
        leads = 0; seen = 0; prev = spi_sclk;
        push(8'hA5); push(8'hB6);
        mode = 0; cs_sel = 0; start = 1;
        for (int n = 0; n < 100 && leads < 4; n++) begin
            @(posedge clk); #1;
            start = 0;
            if (spi_sclk && !prev) leads++;
            prev = spi_sclk;
        end
        total++; if (leads != 4) begin bad++; $display("FAIL rmid_reach got=%0d exp=4", leads); end
        #1 rst_n = 0;
        #1;
        total++; if (spi_cs_n !== 2'b11 || spi_sclk !== 1'b0) begin bad++; $display("FAIL rmid_pins got=%b/%b exp=11/0", spi_cs_n, spi_sclk); end
        total++; if (fifo_count !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_state got=%0d/%b exp=0/0", fifo_count, busy); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || m_valid) seen++;
        end
        rst_n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || m_valid || spi_cs_n !== 2'b11) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rmid_quiet got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_mode3;
        test_cs_range;
        test_full;
        test_empty_start;
        test_mid_start;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
